// File: rtl/sdram_access_ctrl.sv
// Runtime SDRAM command sequencer: single 32-bit word accesses as
// ACTIVE -> READ/WRITE with auto-precharge, plus periodic AUTO REFRESH.
// Device mode assumed: CAS 2, burst 2, sequential, 16-bit DQ.
module sdram_access_ctrl #(
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_RC             = 7,
  parameter int T_WR             = 2,
  parameter int CAS              = 2,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_fin,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_LDQM,
  output logic        DRAM_UDQM,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic [15:0] dq_in
);

  localparam int RW = $clog2(REFRESH_INTERVAL);
  localparam int TW = $clog2(T_RC + 1);
  localparam int CW = 4;

  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_INTERVAL - 1);
  localparam logic [TW-1:0] TRC_L    = TW'(T_RC - 1);
  localparam logic [CW-1:0] RCD_L    = CW'(T_RCD - 1);
  localparam logic [CW-1:0] WREC_L   = CW'(T_WR + T_RP);
  localparam logic [CW-1:0] CAS_C0   = CW'(CAS);
  localparam logic [CW-1:0] CAS_C1   = CW'(CAS + 1);
  localparam logic [CW-1:0] CAS_C2   = CW'(CAS + 2);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [2:0] {
    WAIT_INIT, IDLE, REFRESH, ACTIVATE, RW_CMD, READ_WAIT, WRITE_RECOVER
  } state_t;

  state_t        state;
  logic [3:0]    cmd;
  logic [1:0]    dqm;          // {UDQM, LDQM}
  logic [RW-1:0] ref_cnt;
  logic          ref_pending;
  logic [TW-1:0] trc_cnt;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [23:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic [15:0]   rd_lo;

  logic trc_done, ref_wrap, issue_ref;

  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd;
  assign {DRAM_UDQM, DRAM_LDQM} = dqm;

  assign trc_done  = (trc_cnt == '0);
  assign ref_wrap  = (state != WAIT_INIT) && (ref_cnt == REF_LAST);
  assign issue_ref = (state == IDLE) && trc_done && ref_pending;
  // Refresh always wins over a waiting request, so ready drops while one is pending.
  assign req_ready = (state == IDLE) && !ref_pending && trc_done;

  // Refresh interval timer; starts once init has handed over the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (state != WAIT_INIT) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      // A wrap on the same cycle as the REFRESH issue re-arms the request.
      ref_pending <= (ref_pending && !issue_ref) || ref_wrap;
    end
  end

  // Command sequencer with registered pin outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_INIT;
      cmd       <= CMD_NOP;
      DRAM_ADDR <= '0;
      DRAM_BA   <= '0;
      dqm       <= 2'b11;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      trc_cnt   <= '0;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rd_lo     <= '0;
    end else begin
      cmd       <= CMD_NOP;
      rsp_valid <= 1'b0;
      if (!trc_done) trc_cnt <= trc_cnt - 1'b1;
      case (state)
        WAIT_INIT: if (init_fin) state <= IDLE;
        IDLE: begin
          if (issue_ref) begin
            cmd       <= CMD_REF;
            DRAM_ADDR <= 13'h0400;
            trc_cnt   <= TRC_L;
            state     <= REFRESH;
          end else if (req_valid && req_ready) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wmask_q   <= req_wmask;
            cmd       <= CMD_ACT;
            DRAM_ADDR <= req_addr[23:11];
            DRAM_BA   <= req_addr[10:9];
            trc_cnt   <= TRC_L;
            cnt       <= RCD_L;
            state     <= ACTIVATE;
          end
        end
        REFRESH: if (trc_done) state <= IDLE;
        ACTIVATE: begin
          if (cnt == '0) begin
            cmd       <= we_q ? CMD_WR : CMD_RD;
            DRAM_ADDR <= {2'b00, 1'b1, addr_q[8:0], 1'b0};
            if (we_q) begin
              dq_oe  <= 1'b1;
              dq_out <= wdata_q[15:0];
              dqm    <= ~wmask_q[1:0];
            end else begin
              dqm    <= 2'b00;
            end
            state <= RW_CMD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RW_CMD: begin
          if (we_q) begin
            // Second beat of the burst carries the high halfword.
            dq_out <= wdata_q[31:16];
            dqm    <= ~wmask_q[3:2];
            cnt    <= WREC_L;
            state  <= WRITE_RECOVER;
          end else begin
            cnt   <= CW'(1);
            state <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          // cnt tracks cycles since the READ command.
          cnt <= cnt + 1'b1;
          if (cnt == CAS_C0) begin
            rd_lo <= dq_in;
            dqm   <= 2'b11;
          end
          if (cnt == CAS_C1) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= {dq_in, rd_lo};
          end
          if (cnt == CAS_C2) state <= IDLE;
        end
        WRITE_RECOVER: begin
          dq_oe  <= 1'b0;
          dq_out <= '0;
          dqm    <= 2'b11;
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
